// File: rtl/smi_rx_arbiter.sv
// Round-robin burst scheduler sharing the SMI read path between the two RX channel FIFOs.
// Output words can be tagged in bit 31 with the source channel ID.
module smi_rx_arbiter #(
    parameter int BURST_WORDS = 16,
    parameter bit TAG_EN      = 1'b1
) (
    input  logic        i_sys_clk,
    input  logic        i_rst_b,
    input  logic [1:0]  i_ch_en,
    input  logic        i_ch0_empty,
    input  logic        i_ch1_empty,
    input  logic [31:0] i_ch0_data,
    input  logic [31:0] i_ch1_data,
    output logic        o_ch0_pull,
    output logic        o_ch1_pull,
    input  logic        i_pull,
    output logic [31:0] o_data,
    output logic        o_empty,
    output logic        o_cur_ch,
    output logic        o_pull_err
);

    localparam int CW = $clog2(BURST_WORDS) + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } state_t;

    state_t        state;
    logic          cur_ch;
    logic [CW-1:0] burst_cnt;

    logic [1:0]    elig;
    logic          cur_elig;
    logic          oth_elig;
    logic [CW-1:0] cnt_inc;
    logic          at_limit;
    logic          sel_ch;
    logic          clr_cnt;
    logic          do_select;
    logic [31:0]   fetch_word;

    assign elig     = i_ch_en & {~i_ch1_empty, ~i_ch0_empty};
    assign cur_elig = elig[cur_ch];
    assign oth_elig = elig[~cur_ch];

    // The word being handed out on this cycle's i_pull counts toward the burst
    // before the grant decision, so the limit check sees the incremented value.
    always_comb begin
        cnt_inc = burst_cnt;
        if (state == VALID && i_pull && burst_cnt != {CW{1'b1}})
            cnt_inc = burst_cnt + CW'(1);
    end

    assign at_limit = (cnt_inc >= CW'(BURST_WORDS));

    always_comb begin
        sel_ch  = cur_ch;
        clr_cnt = 1'b0;
        if (at_limit || !cur_elig) begin
            if (oth_elig) begin
                sel_ch  = ~cur_ch;
                clr_cnt = 1'b1;
            end else if (cur_elig) begin
                clr_cnt = 1'b1;
            end
        end
    end

    // Pull strobes are issued in the decision cycle itself so the FIFO data is
    // ready for the following FETCH cycle; reset blocks them outright.
    assign do_select  = i_rst_b && (|elig) &&
                        ((state == IDLE) || (state == VALID && i_pull));
    assign o_ch0_pull = do_select & ~sel_ch;
    assign o_ch1_pull = do_select &  sel_ch;
    assign o_cur_ch   = do_select ? sel_ch : cur_ch;

    always_comb begin
        fetch_word = cur_ch ? i_ch1_data : i_ch0_data;
        if (TAG_EN)
            fetch_word[31] = cur_ch;
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state      <= IDLE;
            cur_ch     <= 1'b0;
            burst_cnt  <= '0;
            o_data     <= 32'h0;
            o_empty    <= 1'b1;
            o_pull_err <= 1'b0;
        end else begin
            if (i_pull && o_empty)
                o_pull_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (do_select) begin
                        cur_ch    <= sel_ch;
                        burst_cnt <= clr_cnt ? '0 : cnt_inc;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    o_data  <= fetch_word;
                    o_empty <= 1'b0;
                    state   <= VALID;
                end
                VALID: begin
                    if (i_pull) begin
                        o_empty <= 1'b1;
                        if (do_select) begin
                            cur_ch    <= sel_ch;
                            burst_cnt <= clr_cnt ? '0 : cnt_inc;
                            state     <= FETCH;
                        end else begin
                            burst_cnt <= cnt_inc;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smi_rx_arbiter.sv
// Directed testbench for smi_rx_arbiter with BURST_WORDS=4, using simple FIFO models
// whose words carry the channel ID and a per-channel sequence number.
module tb_smi_rx_arbiter;

    localparam int BW = 4;

    logic        i_sys_clk = 1'b0;
    logic        i_rst_b   = 1'b0;
    logic [1:0]  i_ch_en   = 2'b00;
    logic        i_ch0_empty;
    logic        i_ch1_empty;
    logic [31:0] i_ch0_data = 32'h0;
    logic [31:0] i_ch1_data = 32'h0;
    logic        o_ch0_pull;
    logic        o_ch1_pull;
    logic        i_pull = 1'b0;
    logic [31:0] o_data;
    logic        o_empty;
    logic        o_cur_ch;
    logic        o_pull_err;

    int checks   = 0;
    int failures = 0;

    int ch0_taken = 0;
    int ch1_taken = 0;
    int ch0_total = 0;
    int ch1_total = 0;
    int viol      = 0;

    smi_rx_arbiter #(.BURST_WORDS(BW), .TAG_EN(1'b1)) dut (
        .i_sys_clk   (i_sys_clk),
        .i_rst_b     (i_rst_b),
        .i_ch_en     (i_ch_en),
        .i_ch0_empty (i_ch0_empty),
        .i_ch1_empty (i_ch1_empty),
        .i_ch0_data  (i_ch0_data),
        .i_ch1_data  (i_ch1_data),
        .o_ch0_pull  (o_ch0_pull),
        .o_ch1_pull  (o_ch1_pull),
        .i_pull      (i_pull),
        .o_data      (o_data),
        .o_empty     (o_empty),
        .o_cur_ch    (o_cur_ch),
        .o_pull_err  (o_pull_err)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    assign i_ch0_empty = (ch0_taken >= ch0_total);
    assign i_ch1_empty = (ch1_taken >= ch1_total);

    // FIFO models: source bit 31 is the opposite of the channel ID so tagging is visible.
    always @(posedge i_sys_clk) begin
        if (o_ch0_pull) begin
            i_ch0_data <= 32'h8000_1000 + 32'(ch0_taken);
            ch0_taken  <= ch0_taken + 1;
        end
        if (o_ch1_pull) begin
            i_ch1_data <= 32'h0000_2000 + 32'(ch1_taken);
            ch1_taken  <= ch1_taken + 1;
        end
        viol <= viol + int'(o_ch0_pull && o_ch1_pull)
                     + int'(o_ch0_pull && i_ch0_empty)
                     + int'(o_ch1_pull && i_ch1_empty);
    end

    task automatic tick();
        @(posedge i_sys_clk);
        #2;
    endtask

    task automatic do_reset();
        i_pull  = 1'b0;
        i_rst_b = 1'b0;
        tick();
        tick();
        i_rst_b = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        for (int i = 0; i < 20; i++) begin
            if (!o_empty) break;
            tick();
        end
        ok = !o_empty;
    endtask

    task automatic pull_word();
        i_pull = 1'b1;
        tick();
        i_pull = 1'b0;
    endtask

    task automatic test_reset();
        i_ch_en = 2'b00;
        do_reset();
        checks++;
        if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty actual=%b expected=1", o_empty); end
        checks++;
        if (o_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data actual=%h expected=00000000", o_data); end
        checks++;
        if ({o_ch1_pull, o_ch0_pull} !== 2'b00) begin failures++; $display("[TB] FAIL reset_pulls actual=%b expected=00", {o_ch1_pull, o_ch0_pull}); end
        checks++;
        if (o_cur_ch !== 1'b0) begin failures++; $display("[TB] FAIL reset_cur_ch actual=%b expected=0", o_cur_ch); end
        checks++;
        if (o_pull_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_pull_err actual=%b expected=0", o_pull_err); end
    endtask

    task automatic test_single_channel();
        int base0, base1;
        bit ok;
        i_ch_en = 2'b00;
        do_reset();
        base0 = ch0_taken;
        base1 = ch1_taken;
        ch0_total = ch0_taken + 5;
        ch1_total = ch1_taken + 5;
        i_ch_en = 2'b01;
        #1;
        checks++;
        if (o_ch0_pull !== 1'b1) begin failures++; $display("[TB] FAIL idle_pull actual=%b expected=1", o_ch0_pull); end
        tick();
        checks++;
        if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL fetch_empty actual=%b expected=1", o_empty); end
        tick();
        checks++;
        if (o_empty !== 1'b0) begin failures++; $display("[TB] FAIL latency_valid actual=%b expected=0", o_empty); end
        for (int k = 0; k < 5; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL single_timeout word=%0d actual=empty expected=valid", k); end
            checks++;
            if (o_data !== 32'h0000_1000 + 32'(base0 + k)) begin
                failures++; $display("[TB] FAIL single_data word=%0d actual=%h expected=%h", k, o_data, 32'h0000_1000 + 32'(base0 + k));
            end
            pull_word();
        end
        tick();
        checks++;
        if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL single_drained actual=%b expected=1", o_empty); end
        checks++;
        if (ch0_taken - base0 !== 5) begin failures++; $display("[TB] FAIL single_ch0_pulls actual=%0d expected=5", ch0_taken - base0); end
        checks++;
        if (ch1_taken - base1 !== 0) begin failures++; $display("[TB] FAIL single_ch1_pulls actual=%0d expected=0", ch1_taken - base1); end
    endtask

    task automatic test_round_robin();
        int base0, base1, idx;
        bit ok, exp_ch;
        logic [31:0] exp;
        i_ch_en = 2'b00;
        do_reset();
        base0 = ch0_taken;
        base1 = ch1_taken;
        ch0_total = ch0_taken + 100;
        ch1_total = ch1_taken + 100;
        i_ch_en = 2'b11;
        for (int k = 0; k < 12; k++) begin
            exp_ch = ((k / 4) % 2) == 1;
            idx    = (k / 8) * 4 + (k % 4);
            exp    = exp_ch ? 32'h8000_2000 + 32'(base1 + idx) : 32'h0000_1000 + 32'(base0 + idx);
            wait_valid(ok);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL rr_timeout word=%0d actual=empty expected=valid", k); end
            checks++;
            if (o_data !== exp) begin failures++; $display("[TB] FAIL rr_data word=%0d actual=%h expected=%h", k, o_data, exp); end
            checks++;
            if (o_cur_ch !== exp_ch) begin failures++; $display("[TB] FAIL rr_cur_ch word=%0d actual=%b expected=%b", k, o_cur_ch, exp_ch); end
            pull_word();
        end
        checks++;
        if (ch0_taken - base0 !== 8) begin failures++; $display("[TB] FAIL rr_ch0_pulls actual=%0d expected=8", ch0_taken - base0); end
    endtask

    task automatic test_ch1_empty();
        int base0, base1;
        bit ok;
        i_ch_en = 2'b00;
        do_reset();
        base0 = ch0_taken;
        base1 = ch1_taken;
        ch0_total = ch0_taken + 100;
        ch1_total = ch1_taken;
        i_ch_en = 2'b11;
        for (int k = 0; k < 10; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok) begin failures++; $display("[TB] FAIL keep_timeout word=%0d actual=empty expected=valid", k); end
            checks++;
            if (o_data !== 32'h0000_1000 + 32'(base0 + k)) begin
                failures++; $display("[TB] FAIL keep_data word=%0d actual=%h expected=%h", k, o_data, 32'h0000_1000 + 32'(base0 + k));
            end
            checks++;
            if (dut.burst_cnt !== 3'(k % 4)) begin
                failures++; $display("[TB] FAIL keep_burst_cnt word=%0d actual=%0d expected=%0d", k, dut.burst_cnt, k % 4);
            end
            pull_word();
        end
        checks++;
        if (ch1_taken - base1 !== 0) begin failures++; $display("[TB] FAIL keep_ch1_pulls actual=%0d expected=0", ch1_taken - base1); end
    endtask

    task automatic test_disable_mid_burst();
        int base0, base1;
        bit ok;
        i_ch_en = 2'b00;
        do_reset();
        base0 = ch0_taken;
        base1 = ch1_taken;
        ch0_total = ch0_taken + 100;
        ch1_total = ch1_taken + 100;
        i_ch_en = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_valid(ok);
            pull_word();
        end
        i_ch_en = 2'b10;
        wait_valid(ok);
        checks++;
        if (o_data !== 32'h0000_1000 + 32'(base0 + 2)) begin
            failures++; $display("[TB] FAIL dis_inflight actual=%h expected=%h", o_data, 32'h0000_1000 + 32'(base0 + 2));
        end
        pull_word();
        wait_valid(ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL dis_timeout actual=empty expected=valid"); end
        checks++;
        if (o_data !== 32'h8000_2000 + 32'(base1)) begin
            failures++; $display("[TB] FAIL dis_next_ch1 actual=%h expected=%h", o_data, 32'h8000_2000 + 32'(base1));
        end
        checks++;
        if (o_cur_ch !== 1'b1) begin failures++; $display("[TB] FAIL dis_cur_ch actual=%b expected=1", o_cur_ch); end
    endtask

    task automatic test_pull_err();
        int base0, base1;
        bit ok;
        i_ch_en = 2'b00;
        do_reset();
        base0 = ch0_taken;
        base1 = ch1_taken;
        ch0_total = ch0_taken + 1;
        ch1_total = ch1_taken + 1;
        pull_word();
        checks++;
        if (o_pull_err !== 1'b1) begin failures++; $display("[TB] FAIL err_set actual=%b expected=1", o_pull_err); end
        checks++;
        if ((ch0_taken - base0) + (ch1_taken - base1) !== 0) begin
            failures++; $display("[TB] FAIL err_no_pull actual=%0d expected=0", (ch0_taken - base0) + (ch1_taken - base1));
        end
        i_ch_en = 2'b01;
        wait_valid(ok);
        pull_word();
        tick();
        checks++;
        if (o_pull_err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky actual=%b expected=1", o_pull_err); end
        i_ch_en = 2'b00;
        do_reset();
        checks++;
        if (o_pull_err !== 1'b0) begin failures++; $display("[TB] FAIL err_cleared actual=%b expected=0", o_pull_err); end
    endtask

    task automatic test_reset_in_fetch();
        int base0, base1;
        bit ok;
        i_ch_en = 2'b00;
        do_reset();
        base0 = ch0_taken;
        base1 = ch1_taken;
        ch0_total = ch0_taken + 10;
        ch1_total = ch1_taken + 10;
        i_ch_en = 2'b10;
        wait_valid(ok);
        checks++;
        if (o_data !== 32'h8000_2000 + 32'(base1)) begin
            failures++; $display("[TB] FAIL rst_pre_data actual=%h expected=%h", o_data, 32'h8000_2000 + 32'(base1));
        end
        pull_word();
        i_rst_b = 1'b0;
        #1;
        checks++;
        if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL rst_fetch_empty actual=%b expected=1", o_empty); end
        checks++;
        if (o_data !== 32'h0) begin failures++; $display("[TB] FAIL rst_fetch_data actual=%h expected=00000000", o_data); end
        checks++;
        if ({o_ch1_pull, o_ch0_pull} !== 2'b00) begin failures++; $display("[TB] FAIL rst_fetch_pulls actual=%b expected=00", {o_ch1_pull, o_ch0_pull}); end
        checks++;
        if (o_cur_ch !== 1'b0) begin failures++; $display("[TB] FAIL rst_fetch_cur_ch actual=%b expected=0", o_cur_ch); end
        i_ch_en = 2'b11;
        tick();
        i_rst_b = 1'b1;
        #1;
        checks++;
        if ({o_ch1_pull, o_ch0_pull} !== 2'b01) begin failures++; $display("[TB] FAIL rst_first_grant actual=%b expected=01", {o_ch1_pull, o_ch0_pull}); end
        wait_valid(ok);
        checks++;
        if (o_data !== 32'h0000_1000 + 32'(base0)) begin
            failures++; $display("[TB] FAIL rst_first_word actual=%h expected=%h", o_data, 32'h0000_1000 + 32'(base0));
        end
        i_ch_en = 2'b00;
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin failures++; $display("[TB] FAIL pull_protocol actual=%0d expected=0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_ch1_empty();
        test_disable_mid_burst();
        test_pull_err();
        test_reset_in_fetch();
        tick();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
